// File: rtl/div_unit.sv
// Multicycle signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per cycle, sign fix-up in a final cycle.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for div_start; zero divisor flagged without leaving
// CALC   | WIDTH shift-subtract steps on magnitudes, count runs down
// FIX    | apply signs, publish hi_out/lo_out, pulse div_done
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_busy,
    output logic             div_done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;

    // Partial remainder shifted left with the next dividend bit; the extra
    // top bit keeps the compare against the divisor from overflowing.
    logic [WIDTH:0]   trial;

    // Next-state and datapath for all three states.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        zero_d    = 1'b0;
        trial     = {rem_q, quo_q[WIDTH-1]};

        case (state_q)
            S_IDLE: begin
                if (div_start) begin
                    if (divisor == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_rem_d = dividend[WIDTH-1];
                        rem_d     = '0;
                        // -(-2^(W-1)) wraps to itself, which is the correct
                        // unsigned magnitude.
                        quo_d     = dividend[WIDTH-1] ? -dividend : dividend;
                        dvs_d     = divisor[WIDTH-1] ? -divisor : divisor;
                        count_d   = CW'(WIDTH);
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
                if (trial >= {1'b0, dvs_q}) begin
                    rem_d    = trial[WIDTH-1:0] - dvs_q;
                    quo_d[0] = 1'b1;
                end else begin
                    rem_d = trial[WIDTH-1:0];
                end
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                lo_d    = neg_quo_q ? -quo_q : quo_q;
                hi_d    = neg_rem_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any divide in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            zero_q    <= zero_d;
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign div_busy = (state_q == S_CALC) || (state_q == S_FIX);
    assign div_done = done_q;
    assign div_zero = zero_q;

endmodule
